// File: rtl/echo_delay_processor.sv
// echo_delay_processor: adds an attenuated copy of the sample from D samples
// earlier to each new ADC sample. The history lives in a circular RAM. D comes
// from the switches and is latched once per sample. FEEDBACK picks what the
// buffer stores: the output y (repeating echo) or the input x (single echo).
module echo_delay_processor #(
  parameter int DW         = 10,
  parameter int ADDR_W     = 13,
  parameter int DELAY_STEP = 8,
  parameter int GAIN_SHIFT = 1,
  parameter int FEEDBACK   = 1
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [DW-1:0]     data_in,
  input  logic              data_valid,
  input  logic [9:0]        sw,
  output logic [DW-1:0]     data_out,
  output logic              out_valid,
  output logic [ADDR_W-1:0] delay_samples,
  output logic              overrun,
  output logic [2:0]        state_dbg
);

  // Handshake: data_valid is a one-cycle pulse and is accepted only in IDLE.
  // A pulse in any other state is dropped and sets the sticky overrun flag.
  // out_valid is a one-cycle pulse, and data_out changes in that same cycle.
  // No backpressure exists.

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CALC, S_WRITE} state_t;

  localparam int STEP_SH = $clog2(DELAY_STEP);
  localparam logic [DW-1:0]          MID      = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW+1:0]   SUM_HI   = (2**(DW-1)) - 1;
  localparam logic signed [DW+1:0]   SUM_LO   = -(2**(DW-1));
  localparam logic signed [DW:0]     Y_HI     = (2**(DW-1)) - 1;
  localparam logic signed [DW:0]     Y_LO     = -(2**(DW-1));
  localparam logic [ADDR_W-1:0]      FILL_MAX = '1;

  state_t                   state_q, state_d;
  logic signed [DW:0]       x_q, x_d;
  logic signed [DW:0]       e_q, e_d;
  logic signed [DW:0]       y_q, y_d;
  logic [ADDR_W-1:0]        dly_q, dly_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        fill_q, fill_d;
  logic [DW-1:0]            dout_q, dout_d;
  logic                     ov_q, ov_d;
  logic [ADDR_W-1:0]        dsamp_q, dsamp_d;
  logic                     overrun_q, overrun_d;

  logic signed [DW:0]       mem [0:(2**ADDR_W)-1];
  logic signed [DW:0]       ram_q;
  logic signed [DW:0]       wr_data;
  logic signed [DW:0]       e_sh;
  logic signed [DW+1:0]     sum;
  logic [ADDR_W-1:0]        d_new;

  assign d_new   = ADDR_W'(sw) << STEP_SH;
  assign wr_data = (FEEDBACK != 0) ? y_q : x_q;
  assign e_sh    = e_q >>> GAIN_SHIFT;
  assign sum     = $signed({x_q[DW], x_q}) + $signed({e_sh[DW], e_sh});

  // History RAM: one write port and a registered read port. The contents are
  // never reset. Entries not yet written are masked by the fill count.
  always_ff @(posedge sysclk) begin
    if (state_q == S_WRITE) mem[wr_ptr_q] <= wr_data;
    if (state_q == S_READ)  ram_q <= mem[rd_addr_q];
  end

  // State and datapath registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      e_q       <= '0;
      y_q       <= '0;
      dly_q     <= '0;
      rd_addr_q <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      dout_q    <= MID;
      ov_q      <= 1'b0;
      dsamp_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      e_q       <= e_d;
      y_q       <= y_d;
      dly_q     <= dly_d;
      rd_addr_q <= rd_addr_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
      ov_q      <= ov_d;
      dsamp_q   <= dsamp_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic. Each sample passes through five states: capture, read,
  // echo select, add with saturation, then write and publish.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    e_d       = e_q;
    y_d       = y_q;
    dly_d     = dly_q;
    rd_addr_d = rd_addr_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    dout_d    = dout_q;
    ov_d      = 1'b0;
    dsamp_d   = dsamp_q;
    overrun_d = overrun_q;
    if (data_valid && (state_q != S_IDLE)) overrun_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          // Convert offset binary to two's complement: invert the MSB and sign-extend.
          x_d       = {~data_in[DW-1], ~data_in[DW-1], data_in[DW-2:0]};
          dly_d     = d_new;
          rd_addr_d = wr_ptr_q - d_new;
          state_d   = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        e_d     = ((dly_q == '0) || (fill_q < dly_q)) ? '0 : ram_q;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (sum > SUM_HI)      y_d = Y_HI;
        else if (sum < SUM_LO) y_d = Y_LO;
        else                   y_d = sum[DW:0];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        dout_d   = {~y_q[DW-1], y_q[DW-2:0]};
        ov_d     = 1'b1;
        dsamp_d  = dly_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_out      = dout_q;
  assign out_valid     = ov_q;
  assign delay_samples = dsamp_q;
  assign overrun       = overrun_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_echo_delay_processor.sv
// Bench for echo_delay_processor. It runs one feed-forward instance and one
// feedback instance side by side. The reference model holds the stored history
// of each mode in a queue, indexed by how many samples ago each entry was written.
module tb_echo_delay_processor;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [9:0]  data_in;
  logic        data_valid;
  logic [9:0]  sw;
  logic [9:0]  out_ff, out_fb;
  logic        ov_ff, ov_fb, orun_ff, orun_fb;
  logic [12:0] ds_ff, ds_fb;
  logic [2:0]  st_ff, st_fb;

  int n_cmp = 0;
  int n_bad = 0;
  int hist_ff[$];
  int hist_fb[$];
  int exp_ff, exp_fb;

  echo_delay_processor #(.FEEDBACK(0)) dut_ff (
    .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .sw(sw), .data_out(out_ff), .out_valid(ov_ff), .delay_samples(ds_ff),
    .overrun(orun_ff), .state_dbg(st_ff)
  );

  echo_delay_processor #(.FEEDBACK(1)) dut_fb (
    .sysclk(sysclk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .sw(sw), .data_out(out_fb), .out_valid(ov_fb), .delay_samples(ds_fb),
    .overrun(orun_fb), .state_dbg(st_fb)
  );

  // Clock: 50 MHz.
  always #10 sysclk = ~sysclk;

  initial begin
    #10ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output of one sample: x plus the echo halved (rounded toward minus
  // infinity), clamped to the signed 10-bit range.
  function automatic int ref_y(input int x, input int e);
    int s;
    s = x + (e >>> 1);
    if (s > 511) s = 511;
    if (s < -512) s = -512;
    return s;
  endfunction

  // Advances both models by one accepted sample and sets exp_ff and exp_fb.
  task automatic model_step(input int din, input int swv);
    int d, x, e, n, y_ff, y_fb;
    x = din - 512;
    d = swv * 8;
    n = hist_ff.size();
    e = (d == 0 || n < d) ? 0 : hist_ff[n - d];
    y_ff = ref_y(x, e);
    n = hist_fb.size();
    e = (d == 0 || n < d) ? 0 : hist_fb[n - d];
    y_fb = ref_y(x, e);
    hist_ff.push_back(x);
    hist_fb.push_back(y_fb);
    if (hist_ff.size() > 8191) void'(hist_ff.pop_front());
    if (hist_fb.size() > 8191) void'(hist_fb.pop_front());
    exp_ff = y_ff + 512;
    exp_fb = y_fb + 512;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_ff"}, out_ff, 512);
    check({tag, "_out_fb"}, out_fb, 512);
    check({tag, "_ov_ff"}, ov_ff, 0);
    check({tag, "_ov_fb"}, ov_fb, 0);
    check({tag, "_orun_ff"}, orun_ff, 0);
    check({tag, "_orun_fb"}, orun_fb, 0);
    check({tag, "_ds_ff"}, ds_ff, 0);
    check({tag, "_ds_fb"}, ds_fb, 0);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst_n = 1'b0;
    data_valid = 1'b0;
    repeat (3) @(negedge sysclk);
    check_idle_outputs("rst");
    // The debug state code reads 0 while the FSM sits idle after reset.
    check("rst_state_ff", st_ff, 0);
    check("rst_state_fb", st_fb, 0);
    rst_n = 1'b1;
    hist_ff.delete();
    hist_fb.delete();
  endtask

  // Sends one sample and checks that the result arrives exactly five cycles
  // later. The switches are scrambled while the sample is in flight.
  task automatic send(input int din, input int swv);
    model_step(din, swv);
    @(negedge sysclk);
    data_in = 10'(din);
    sw = 10'(swv);
    data_valid = 1'b1;
    @(negedge sysclk);
    data_valid = 1'b0;
    sw = 10'($urandom_range(0, 1023));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge sysclk);
      check("early_ov_ff", ov_ff, 0);
      check("early_ov_fb", ov_fb, 0);
    end
    @(negedge sysclk);
    check("ov_ff", ov_ff, 1);
    check("ov_fb", ov_fb, 1);
    check("out_ff", out_ff, exp_ff);
    check("out_fb", out_fb, exp_fb);
    check("ds_ff", ds_ff, swv * 8);
    check("ds_fb", ds_fb, swv * 8);
    check("orun_ff", orun_ff, 0);
    check("orun_fb", orun_fb, 0);
  endtask

  initial begin
    int cnt_ff, cnt_fb, seen_ff, seen_fb;
    rst_n = 1'b0;
    data_valid = 1'b0;
    data_in = 10'd512;
    sw = 10'd0;

    // Reset state, then idle with no samples.
    repeat (3) @(negedge sysclk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge sysclk);
    check_idle_outputs("idle");

    // Bypass: with D = 0 the output equals the input.
    send(700, 0);
    check("bypass700", out_ff, 700);
    send(300, 0);
    check("bypass300", out_fb, 300);
    send(1023, 0);
    check("bypass1023", out_ff, 1023);

    // Impulse with D = 8 in both echo modes.
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      send((i == 0) ? 900 : 512, 1);
      if (i == 0)  check("imp_ff0", out_ff, 900);
      if (i == 7)  check("imp_ff7", out_ff, 512);
      if (i == 8)  check("imp_ff8", out_ff, 706);
      if (i == 16) check("imp_ff16", out_ff, 512);
      if (i == 8)  check("imp_fb8", out_fb, 706);
      if (i == 16) check("imp_fb16", out_fb, 609);
      if (i == 24) check("imp_fb24", out_fb, 560);
    end

    // Full scale for longer than the buffer depth: the output clamps and the write pointer wraps.
    do_reset();
    for (int i = 0; i < 9000; i++) send(1023, 1);
    check("sat_ff", out_ff, 1023);
    check("sat_fb", out_fb, 1023);

    // Random samples and delays, reading the history left by the steps above.
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 1023),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 4));
    end

    // Overrun: a second pulse two cycles after the first is dropped.
    do_reset();
    model_step(800, 0);
    @(negedge sysclk);
    data_in = 10'd800; sw = 10'd0; data_valid = 1'b1;
    @(negedge sysclk);
    data_valid = 1'b0;
    @(negedge sysclk);
    data_in = 10'd100; data_valid = 1'b1;
    @(negedge sysclk);
    data_valid = 1'b0;
    cnt_ff = 0; cnt_fb = 0; seen_ff = 0; seen_fb = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sysclk);
      if (ov_ff) begin cnt_ff++; seen_ff = int'(out_ff); end
      if (ov_fb) begin cnt_fb++; seen_fb = int'(out_fb); end
    end
    check("orun_pulses_ff", cnt_ff, 1);
    check("orun_pulses_fb", cnt_fb, 1);
    check("orun_data_ff", seen_ff, exp_ff);
    check("orun_data_fb", seen_fb, exp_fb);
    check("orun_flag_ff", orun_ff, 1);
    check("orun_flag_fb", orun_fb, 1);

    // Reset asserted while a sample is in CALC: no pulse, and the output returns to midscale.
    @(negedge sysclk);
    data_in = 10'd200; sw = 10'd0; data_valid = 1'b1;
    @(negedge sysclk);
    data_valid = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b0;
    cnt_ff = 0; cnt_fb = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sysclk);
      if (ov_ff) cnt_ff++;
      if (ov_fb) cnt_fb++;
    end
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    hist_ff.delete();
    hist_fb.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge sysclk);
      if (ov_ff) cnt_ff++;
      if (ov_fb) cnt_fb++;
    end
    check("midrst_pulses_ff", cnt_ff, 0);
    check("midrst_pulses_fb", cnt_fb, 0);
    check("midrst_hold_ff", out_ff, 512);
    send(650, 0);
    check("after_rst", out_fb, 650);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/echo_delay_processor.md
Name: echo_delay_processor

Overview:
Sample-rate processing stage between the SPI ADC interface and the SPI DAC driver in the variable-delay echo synthesiser. Each converted 10-bit ADC sample is added to an attenuated copy of the signal from D samples earlier, read from an on-chip circular buffer, and the result is presented to the DAC. The delay D is set from the board switches. Echo mode is feed-forward or feedback, chosen at build time.

Parameters:
DW, 10, sample width in and out (offset binary, midscale 512)
ADDR_W, 13, buffer address width; depth 2^ADDR_W = 8192 samples (819.2 ms at 10 kHz)
DELAY_STEP, 8, samples of delay per switch LSB (power of two)
GAIN_SHIFT, 1, echo attenuation as an arithmetic right shift (1 = half amplitude)
FEEDBACK, 1, 1 = store output y in the buffer (repeating echo); 0 = store input x (single echo)

Ports:
sysclk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
data_in  in  10  ADC sample, offset binary
data_valid  in  1  one-cycle pulse; data_in is valid this cycle
sw  in  10  delay select; D = sw * DELAY_STEP samples
data_out  out  10  processed sample to the DAC, offset binary; holds between samples
out_valid  out  1  one-cycle pulse when data_out updates
delay_samples  out  13  D latched for the current/last sample (for display)
overrun  out  1  sticky; set when data_valid arrives while not IDLE

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, wr_ptr=0, fill=0, data_out=512, out_valid=0, delay_samples=0, overrun=0. Buffer RAM contents are not cleared; stale data is masked via fill.
- Storage: single-port-read/single-port-write synchronous RAM, 2^ADDR_W x 11 bits signed, 1-cycle registered read.
- FSM:
  IDLE: on data_valid, x <= data_in - 512 (11-bit signed); D <= sw*DELAY_STEP (sw is sampled only here); rd_addr <= wr_ptr - D mod 2^ADDR_W; go to READ.
  READ: RAM read issued at rd_addr; go to WAIT.
  WAIT: RAM data available; e <= (D==0 or fill<D) ? 0 : ram_q; go to CALC.
  CALC: s = x + (e >>> GAIN_SHIFT), 12-bit signed; saturate to [-512,511]; y <= sat; go to WRITE.
  WRITE: mem[wr_ptr] <= FEEDBACK ? y : x; wr_ptr <= wr_ptr+1 (wraps 8191->0); fill <= min(fill+1, 8191); data_out <= y+512; out_valid=1 this cycle; delay_samples <= D; go to IDLE.
- Latency: data_valid at cycle N -> out_valid and new data_out at cycle N+5. Busy for 5 cycles per sample, far below the 5000-cycle sample period.
- data_valid outside IDLE: the sample is dropped and overrun is set (cleared only by reset).
- D==0: echo term forced to 0 and data_out equals data_in exactly. With FEEDBACK=1 the buffer is still written.
- Maximum D = 1023*8 = 8184 < 8192, so the read address never equals the write address.
- Saturation: data_out clamps at 0 and 1023 and never wraps.
- Switch change: takes effect on the next data_valid only. fill is not reset, so the new delay reads previously written history immediately if fill >= D.
- Reset mid-operation: in-flight sample discarded, no out_valid, data_out returns to 512.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> data_out=512, out_valid=0, overrun=0. Release; no data_valid -> outputs unchanged.
- Bypass: sw=0, data_valid pulses with data_in 700, 300, 1023 -> data_out equals input each time, out_valid exactly 5 cycles after each data_valid.
- Single echo, FEEDBACK=0: sw=1 (D=8), impulse data_in=900 then 512 repeated -> output 900, then 512 for 7 samples, then 512+194=706 at sample 8, then 512 after that.
- Feedback decay, FEEDBACK=1: same impulse -> echoes at 8,16,24 of 706, 609, 560 (offset 194, 97, 48), then decaying to 512.
- Saturation and wrap: D=8, constant data_in=1023 for 9000 samples -> data_out clamps to 1023 with no wrap. wr_ptr passes 8191->0 with no glitch in the echo timing.
- Overrun and mid-op reset: second data_valid 2 cycles after the first -> overrun=1, one out_valid only. Separately, assert rst_n during CALC -> no out_valid, data_out=512.
